demux_feeder: RTL and testbench

- Upstream feeder for the 4-way 64-bit demux stage.
- Accepts a valid/ready stream of 64-bit words and buffers them in a small FIFO.
- Issues one word per cycle with a 2-bit lane select on `out_ctrl`, gated by per-lane ready.
- Lane is chosen either from a per-word destination tag or by round-robin.

---
 rtl/demux_feeder.sv | 122 ++++++++++++
 tb/tb_demux_feeder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_feeder.sv
// demux_feeder: buffers a 64-bit valid/ready stream and issues one word per cycle to a 4-lane demux.
// Latency: a word offered to an empty FIFO shows on out_* two cycles later; 1 word/cycle sustained.
// Backpressure: in_ready low when full; the head stalls while its selected lane is not ready.
// Optional feature macro: DEMUX_FEEDER_STATS_EN adds per-lane pop counters on lane_count.
module demux_feeder #(
  parameter int DEPTH           = 8,
  parameter bit RR_MODE_DEFAULT = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    mode_rr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [63:0]             in_data,
  input  logic [1:0]              in_dest,
  input  logic [3:0]              lane_ready,
  output logic                    out_valid,
  output logic [1:0]              out_ctrl,
  output logic [63:0]             out_data,
  output logic [$clog2(DEPTH):0]  fifo_level
`ifdef DEMUX_FEEDER_STATS_EN
  ,
  output logic [127:0]            lane_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Each entry holds {dest, data}.
  logic [65:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [1:0]    rr_ptr;
  logic          mode_q;
  logic          alive;
  logic [65:0]   head;
  logic [1:0]    sel_lane;
  logic          push;
  logic          pop;

  // Lane choice for the head word: its own tag, or the round-robin pointer.
  assign head       = mem[rd_ptr];
  assign sel_lane   = mode_q ? rr_ptr : head[65:64];
  // alive keeps in_ready low until the first clock after reset release.
  assign in_ready   = alive && (level < LW'(DEPTH));
  assign push       = in_valid && in_ready && !flush;
  assign pop        = (level != '0) && lane_ready[sel_lane] && !flush;
  assign fifo_level = level;

  // Storage array, written only by an accepted push; contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_dest, in_data};
    end
  end

  // Pointers and occupancy; flush discards any push or pop of the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // Mode bit is registered, so a change steers the pop decision of the following cycle.
  // The RR pointer only advances on pops made in RR mode and never skips a busy lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive  <= 1'b0;
      mode_q <= RR_MODE_DEFAULT;
      rr_ptr <= 2'd0;
    end else begin
      alive  <= 1'b1;
      mode_q <= mode_rr;
      if (flush) begin
        rr_ptr <= 2'd0;
      end else if (pop && mode_q) begin
        rr_ptr <= rr_ptr + 2'd1;
      end
    end
  end

  // Registered output stage; out_ctrl keeps its last lane when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ctrl  <= 2'd0;
      out_data  <= 64'd0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_ctrl  <= sel_lane;
      out_data  <= head[63:0];
    end else begin
      out_valid <= 1'b0;
      out_data  <= 64'd0;
    end
  end

`ifdef DEMUX_FEEDER_STATS_EN
  // Per-lane pop counters; cleared by reset only so they survive a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_count <= '0;
    end else if (pop) begin
      lane_count[{sel_lane, 5'b0} +: 32] <= lane_count[{sel_lane, 5'b0} +: 32] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_feeder.sv
// tb_demux_feeder: directed and randomized checks of demux_feeder against a queue-based model.
// Latency: inputs driven on the falling edge, outputs sampled on the following falling edge.
// Backpressure: lane_ready patterns drive stalls, fill and head-of-line blocking.
module tb_demux_feeder;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        mode_rr = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic [1:0]  in_dest = 2'd0;
  logic [3:0]  lane_ready = 4'd0;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_ctrl;
  logic [63:0] out_data;
  logic [3:0]  fifo_level;
`ifdef DEMUX_FEEDER_STATS_EN
  logic [127:0] lane_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  demux_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .mode_rr(mode_rr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_dest(in_dest),
    .lane_ready(lane_ready),
    .out_valid(out_valid),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .fifo_level(fifo_level)
`ifdef DEMUX_FEEDER_STATS_EN
    ,
    .lane_count(lane_count)
`endif
  );

  always #5 clk = ~clk;

  wire [71:0] obs = {in_ready, out_valid, out_ctrl, out_data, fifo_level};

  // Reference model: a queue of {dest, data} words plus the visible output registers.
  logic [65:0] q[$];
  bit          m_alive = 1'b0;
  bit          m_mode  = 1'b0;
  int          m_rr    = 0;
  bit          e_valid = 1'b0;
  logic [1:0]  e_ctrl  = 2'd0;
  logic [63:0] e_data  = 64'd0;
`ifdef DEMUX_FEEDER_STATS_EN
  logic [31:0] m_cnt [4];
`endif

  // Model update once per rising edge from the inputs that were set up before it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_alive = 1'b0;
      m_mode  = 1'b0;
      m_rr    = 0;
      e_valid = 1'b0;
      e_ctrl  = 2'd0;
      e_data  = 64'd0;
`ifdef DEMUX_FEEDER_STATS_EN
      foreach (m_cnt[i]) m_cnt[i] = 32'd0;
`endif
    end else begin
      bit          do_push;
      bit          do_pop;
      int          lane;
      logic [65:0] w;
      do_push = in_valid && m_alive && (q.size() < DEPTH) && !flush;
      do_pop  = 1'b0;
      lane    = 0;
      if (q.size() > 0) begin
        lane   = m_mode ? m_rr : int'(q[0][65:64]);
        do_pop = lane_ready[lane] && !flush;
      end
      if (flush) begin
        q.delete();
        m_rr    = 0;
        e_valid = 1'b0;
        e_data  = 64'd0;
      end else begin
        if (do_pop) begin
          w       = q.pop_front();
          e_valid = 1'b1;
          e_ctrl  = 2'(lane);
          e_data  = w[63:0];
`ifdef DEMUX_FEEDER_STATS_EN
          m_cnt[lane] = m_cnt[lane] + 32'd1;
`endif
          if (m_mode) m_rr = (m_rr + 1) % 4;
        end else begin
          e_valid = 1'b0;
          e_data  = 64'd0;
        end
        if (do_push) q.push_back({in_dest, in_data});
      end
      m_mode  = mode_rr;
      m_alive = 1'b1;
    end
  end

  function automatic logic [71:0] exp_vec();
    return {m_alive && (q.size() < DEPTH), e_valid, e_ctrl, e_data, 4'(q.size())};
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 72'd0) begin
      n_fail++; $display("FAIL reset_async: got %h want 0", obs);
    end
    in_valid = 1'b0; flush = 1'b0; mode_rr = 1'b0; lane_ready = 4'd0;
    @(negedge clk);
    n_checks++;
    if (obs !== 72'd0) begin
      n_fail++; $display("FAIL reset_held: got %h want 0", obs);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_clock: got %b want 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL ready_after_clock: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_tag_order();
    logic [63:0] d [4];
    int seen  = 0;
    int first = -1;
    mode_rr = 1'b0; lane_ready = 4'hF;
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4);
      in_dest  = 2'(c);
      in_data  = d[c % 4];
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL tag_model c=%0d: got %h want %h", c, obs, exp_vec());
      end
      if (out_valid) begin
        if (first < 0) first = c;
        n_checks++;
        if (seen >= 4) begin
          n_fail++; $display("FAIL tag_extra: got word %0d want 4 words", seen);
        end else if (out_ctrl !== 2'(seen) || out_data !== d[seen]) begin
          n_fail++; $display("FAIL tag_word%0d: got %0d/%h want %0d/%h", seen, out_ctrl, out_data, seen, d[seen]);
        end
        seen++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (first !== 1 || seen !== 4) begin
      n_fail++; $display("FAIL tag_timing: got first=%0d n=%0d want first=1 n=4", first, seen);
    end
  endtask

  task automatic test_rr();
    int seen = 0;
    mode_rr = 1'b1; flush = 1'b1; in_valid = 1'b0; lane_ready = 4'hF;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 6);
      in_dest  = 2'd3;
      in_data  = {$urandom, $urandom};
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL rr_model c=%0d: got %h want %h", c, obs, exp_vec());
      end
      if (out_valid) begin
        n_checks++;
        if (out_ctrl !== 2'(seen % 4)) begin
          n_fail++; $display("FAIL rr_lane%0d: got %0d want %0d", seen, out_ctrl, seen % 4);
        end
        seen++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (seen !== 6) begin
      n_fail++; $display("FAIL rr_count: got %0d want 6", seen);
    end
  endtask

  task automatic test_fill();
    int acc  = 0;
    int outn = 0;
    bit pre;
    mode_rr = 1'b0; flush = 1'b1; in_valid = 1'b0; lane_ready = 4'd0;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (acc < 9); in_dest = 2'd0; in_data = 64'hF000 + 64'(acc);
      pre = in_ready && in_valid;
      @(negedge clk);
      if (pre) acc++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL fill_model c=%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    n_checks++;
    if (acc !== 8 || fifo_level !== 4'd8 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got acc=%0d lvl=%0d rdy=%b want 8/8/0", acc, fifo_level, in_ready);
    end
    lane_ready = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || fifo_level !== 4'd7 || out_valid !== 1'b1 || out_data !== 64'hF000) begin
      n_fail++; $display("FAIL fill_first_pop: got %h want rdy=1 lvl=7 data=f000", obs);
    end
    outn = 1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (acc < 9); in_data = 64'hF000 + 64'(acc);
      pre = in_ready && in_valid;
      @(negedge clk);
      if (pre) acc++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL drain_model c=%0d: got %h want %h", c, obs, exp_vec());
      end
      if (out_valid) begin
        n_checks++;
        if (out_data !== 64'hF000 + 64'(outn)) begin
          n_fail++; $display("FAIL drain_order: got %h want %h", out_data, 64'hF000 + 64'(outn));
        end
        outn++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc !== 9 || outn !== 9 || fifo_level !== 4'd0) begin
      n_fail++; $display("FAIL fill_total: got acc=%0d out=%0d lvl=%0d want 9/9/0", acc, outn, fifo_level);
    end
  endtask

  task automatic test_hol();
    logic [63:0] w = {$urandom, $urandom};
    mode_rr = 1'b0; flush = 1'b1; in_valid = 1'b0; lane_ready = 4'b1011;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; in_dest = 2'd2; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || fifo_level !== 4'd1 || obs !== exp_vec()) begin
        n_fail++; $display("FAIL hol_stall c=%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    lane_ready = 4'hF;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 2'd2 || out_data !== w) begin
      n_fail++; $display("FAIL hol_release: got %b/%0d/%h want 1/2/%h", out_valid, out_ctrl, out_data, w);
    end
  endtask

  task automatic test_flush();
    mode_rr = 1'b0; flush = 1'b1; in_valid = 1'b0; lane_ready = 4'd0;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_dest = 2'(c); in_data = {$urandom, $urandom};
      @(negedge clk);
    end
    n_checks++;
    if (fifo_level !== 4'd5) begin
      n_fail++; $display("FAIL flush_pre_level: got %0d want 5", fifo_level);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD_BEEF;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; lane_ready = 4'hF;
    n_checks++;
    if (fifo_level !== 4'd0 || out_valid !== 1'b0 || out_data !== 64'd0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL flush_clear: got %h want %h", obs, exp_vec());
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
      n_fail++; $display("FAIL flush_discard: got valid=%b lvl=%0d want 0/0", out_valid, fifo_level);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = {$urandom, $urandom};
      in_dest    = 2'($urandom_range(0, 3));
      lane_ready = 4'($urandom_range(0, 15)) | (($urandom_range(0, 1) != 0) ? 4'hF : 4'h0);
      flush      = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 15) == 0) mode_rr = ~mode_rr;
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL rand_model c=%0d: got %h want %h", c, obs, exp_vec());
      end
`ifdef DEMUX_FEEDER_STATS_EN
      n_checks++;
      if (lane_count !== {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]}) begin
        n_fail++; $display("FAIL rand_stats c=%0d: got %h want %h", c, lane_count, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
      end
`endif
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

`ifdef DEMUX_FEEDER_STATS_EN
  task automatic test_stats();
    test_reset();
    mode_rr = 1'b1; lane_ready = 4'hF;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 10); in_dest = 2'd3; in_data = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (lane_count !== {32'd2, 32'd2, 32'd3, 32'd3}) begin
      n_fail++; $display("FAIL stats_rr10: got %h want 2,2,3,3", lane_count);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (lane_count !== {32'd2, 32'd2, 32'd3, 32'd3}) begin
      n_fail++; $display("FAIL stats_flush_keep: got %h want 2,2,3,3", lane_count);
    end
    test_reset();
    n_checks++;
    if (lane_count !== 128'd0) begin
      n_fail++; $display("FAIL stats_reset: got %h want 0", lane_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tag_order();
    test_rr();
    test_fill();
    test_hol();
    test_flush();
    test_random();
    // Mid-operation reset: the random run leaves words and output state behind.
    lane_ready = 4'd0; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
`ifdef DEMUX_FEEDER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
